// File: rtl/dp_pkg.sv
// Shared definitions for the single-bus datapath: opcode encodings, sequencer
// states and a constant-foldable address-width helper.
package dp_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_SHL1 = 3'b101;
   localparam logic [2:0] OP_SHR1 = 3'b110;
   localparam logic [2:0] OP_LDI  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_T0   = 2'd1,
      ST_T1   = 2'd2,
      ST_T2   = 2'd3
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: Y is the latched first operand, b is the T1 bus value.
// LDI passes b straight through; the sequencer decides what happens to carry.
module dp_alu
   import dp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] z,
   output logic             carry_out
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum       = '0;
      z         = '0;
      carry_out = 1'b0;
      case (op)
         OP_ADD: begin
            sum       = {1'b0, y} + {1'b0, b};
            z         = sum[WIDTH-1:0];
            carry_out = sum[WIDTH];
         end
         OP_SUB: begin
            // carry set means no borrow
            sum       = {1'b0, y} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            z         = sum[WIDTH-1:0];
            carry_out = sum[WIDTH];
         end
         OP_AND:  z = y & b;
         OP_OR:   z = y | b;
         OP_XOR:  z = y ^ b;
         OP_SHL1: begin
            z         = {y[WIDTH-2:0], 1'b0};
            carry_out = y[WIDTH-1];
         end
         OP_SHR1: begin
            z         = {1'b0, y[WIDTH-1:1]};
            carry_out = y[0];
         end
         default: z = b;
      endcase
   end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus register file / Y / ALU / Z datapath with a T0-T1-T2 micro-sequencer
// and a start/busy/done handshake; one bus driver per state.
module bus_datapath_seq
   import dp_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NUM_REGS = 8,
   parameter int R0_ZERO  = 1
) (
   input  logic                        clock,
   input  logic                        clear,
   input  logic                        start,
   input  logic [2:0]                  op,
   input  logic [clog2(NUM_REGS)-1:0]  rd,
   input  logic [clog2(NUM_REGS)-1:0]  rs1,
   input  logic [clog2(NUM_REGS)-1:0]  rs2,
   input  logic                        imm_en,
   input  logic [WIDTH-1:0]            imm,
   output logic                        busy,
   output logic                        done,
   output logic [WIDTH-1:0]            result,
   output logic                        carry,
   output logic                        zero,
   input  logic [clog2(NUM_REGS)-1:0]  dbg_sel,
   output logic [WIDTH-1:0]            dbg_data
);

   localparam int AW = clog2(NUM_REGS);

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [AW-1:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic             imm_en_q, imm_en_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic [WIDTH-1:0] y_q, y_d, z_q, z_d, result_q, result_d;
   logic             carry_q, carry_d, zero_q, zero_d, done_q, done_d;

   logic [WIDTH-1:0] reg_view [NUM_REGS];
   logic [WIDTH-1:0] rs1_val, rs2_val, bus, alu_z;
   logic             alu_c, reg_we;

   // Each register is its own flop bank; R0 collapses to a constant when hard-wired.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (R0_ZERO != 0 && gi == 0) begin : g_zero
         assign reg_view[gi] = '0;
      end else begin : g_store
         logic [WIDTH-1:0] r_q, r_d;
         always_comb begin
            r_d = r_q;
            if (reg_we && rd_q == AW'(gi)) r_d = bus;
         end
         always_ff @(posedge clock or negedge clear) begin
            if (!clear) r_q <= '0;
            else        r_q <= r_d;
         end
         assign reg_view[gi] = r_q;
      end
   end

   // Addresses past NUM_REGS match no entry and read as zero.
   always_comb begin
      rs1_val  = '0;
      rs2_val  = '0;
      dbg_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rs1_q == AW'(i))   rs1_val  = reg_view[i];
         if (rs2_q == AW'(i))   rs2_val  = reg_view[i];
         if (dbg_sel == AW'(i)) dbg_data = reg_view[i];
      end
   end

   always_comb begin
      bus = '0;
      case (state_q)
         ST_T0:   bus = rs1_val;
         ST_T1:   bus = (imm_en_q || op_q == OP_LDI) ? imm_q : rs2_val;
         ST_T2:   bus = z_q;
         default: bus = '0;
      endcase
   end

   dp_alu #(.WIDTH(WIDTH)) u_alu (
      .y         (y_q),
      .b         (bus),
      .op        (op_q),
      .z         (alu_z),
      .carry_out (alu_c)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      imm_en_d = imm_en_q;
      imm_d    = imm_q;
      y_d      = y_q;
      z_d      = z_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      reg_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d     = op;
               rd_d     = rd;
               rs1_d    = rs1;
               rs2_d    = rs2;
               imm_en_d = imm_en;
               imm_d    = imm;
               state_d  = (op == OP_LDI) ? ST_T1 : ST_T0;
            end
         end
         ST_T0: begin
            y_d     = bus;
            state_d = ST_T1;
         end
         ST_T1: begin
            z_d     = alu_z;
            if (op_q != OP_LDI) carry_d = alu_c;
            zero_d  = (alu_z == '0);
            state_d = ST_T2;
         end
         ST_T2: begin
            reg_we   = 1'b1;
            result_d = bus;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_en_q <= 1'b0;
         imm_q    <= '0;
         y_q      <= '0;
         z_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_en_q <= imm_en_d;
         imm_q    <= imm_d;
         y_q      <= y_d;
         z_q      <= z_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         done_q   <= done_d;
      end
   end

   assign busy   = (state_q != ST_IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign carry  = carry_q;
   assign zero   = zero_q;

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
Parametrised successor to the single-bus register/adder datapath. It holds a general register file, a Y operand register, an ALU, and a Z result register, all around one shared internal bus. A built-in micro-sequencer runs each register-to-register or immediate instruction as timed bus transfers (T0/T1/T2). A start/busy/done handshake lets the future control unit issue one op at a time.

Parameters:
WIDTH, 8, data and bus width in bits (>=4)
NUM_REGS, 8, number of general registers (2..32); address width AW = clog2(NUM_REGS)
R0_ZERO, 1, when 1, R0 reads as 0 on the bus and writes to R0 are discarded

Ports:
clock  in  1  single clock, rising edge
clear  in  1  asynchronous, active-low reset
start  in  1  issue request; accepted only in IDLE
op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1, 111 LDI
rd  in  AW  destination register
rs1  in  AW  first source (ignored for LDI)
rs2  in  AW  second source (ignored when imm_en=1, shifts, or LDI)
imm_en  in  1  second operand taken from imm instead of rs2
imm  in  WIDTH  immediate operand
busy  out  1  high while an op is in T0..T2
done  out  1  one-cycle pulse after rd has been written
result  out  WIDTH  last value written to rd; held until next done
carry  out  1  ALU carry flag
zero  out  1  ALU zero flag
dbg_sel  in  AW  debug read address
dbg_data  out  WIDTH  combinational read of register dbg_sel (R0_ZERO honoured)

Behaviour:
- Reset (clear=0, async): all registers, Y, Z, result, carry and zero go to 0. FSM goes to IDLE; busy=0, done=0. A reset mid-op aborts the op with no register write.
- FSM states: IDLE, T0, T1, T2.
- IDLE & start=1: latch op, rd, rs1, rs2, imm_en, imm. Next state is T0, or T1 directly for LDI.
- start is ignored outside IDLE (no queueing).
- start in the done cycle is accepted, because that cycle is IDLE.
- T0: bus = Reg[rs1]; Y <= bus at clock edge.
- T1: bus = imm if (imm_en or LDI), else Reg[rs2]. Z <= ALU(Y, bus); for LDI, Z <= bus. Flags update at this edge. For LDI, carry is kept and zero = (imm==0).
- T2: bus = Z; Reg[rd] <= bus; result <= bus; done <= 1 for the next cycle; next state is IDLE.
- Latency, start edge to done high: ALU ops 4 cycles, LDI 3 cycles.
- busy is combinational: (state != IDLE).
- Arithmetic is WIDTH bits, wrapping.
- ADD: carry = carry-out.
- SUB: Y + ~bus + 1; carry = 1 when no borrow (Y >= bus unsigned).
- AND/OR/XOR: carry = 0.
- SHL1: shifts Y left 1, carry = Y[WIDTH-1]. SHR1: logical shift right 1, carry = Y[0]. The T1 bus value is unused for shifts.
- zero = (Z_next == 0).
- rd equal to rs1 or rs2 is legal: operands are captured before the T2 write.
- R0_ZERO=1: reads of R0 drive 0; a write to R0 still produces done and result, but the register is unchanged.
- Address >= NUM_REGS: reads drive 0, writes are dropped, done still pulses.
- Exactly one bus driver per state. In IDLE the bus drives 0.

Decomposition:
- Package dp_pkg holds:
  - op encodings (OP_ADD..OP_LDI, 3-bit)
  - FSM state enum (IDLE/T0/T1/T2)
  - a clog2 helper for AW
- Sub-module dp_alu: combinational, parametrised by WIDTH. Inputs y, b, op; outputs z, carry_out. Instantiated once.
- The register file, bus mux and FSM stay in bus_datapath_seq.

Test Plan:
- Reset: load regs, pulse clear low mid-T1 -> all dbg_data reads 0, busy=0, done=0, and no write occurs after release.
- LDI R1=0x05 then LDI R2=0xFB; ADD rd=3 rs1=1 rs2=2 -> done 4 cycles after start, R3=0x00, result=0x00, carry=1, zero=1.
- SUB rd=4 rs1=1(0x05) imm_en imm=0x07 -> R4=0xFE, carry=0, zero=0. Then SUB R4-R4 into R4 -> R4=0x00, carry=1, zero=1.
- SHL1 on R2=0xFB -> 0xF6, carry=1. SHR1 on R1=0x05 -> 0x02, carry=1. XOR R1,R1 -> 0x00, carry=0.
- Handshake: start held high continuously -> exactly one op accepted per 4 cycles. Start pulses during T0..T2 are ignored. Back-to-back start in the done cycle is accepted.
- R0_ZERO=1: LDI R0=0xAA -> done pulses, result=0xAA, but dbg_data(R0)=0. ADD R5=R0+R1 -> 0x05. With NUM_REGS=6, LDI to address 7 -> no register changes.
